// File: rtl/cover_toggle_sched.sv
// Round-robin scheduler draining a sticky toggle-coverage pending bitmap onto one valid/ready report channel.
// Optional COVER_DEDUP_EN: report each cover bit at most once between resets.
module cover_toggle_sched #(
  parameter int unsigned     WIDTH       = 22,
  parameter longint unsigned COVER_INDEX = 0,
  parameter longint unsigned COVER_TOTAL = 38253
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_index,
  output logic             busy,
  output logic [15:0]      hit_count,
  output logic [15:0]      merge_count
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CNT_W = 16;

  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_index_q, out_index_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] merge_q, merge_d;

  logic [WIDTH-1:0] mask, cap, ge_rr, hi, search, grant_vec;
  logic [IDX_W-1:0] sel_idx;
  logic             load, do_grant, merge_hit;

`ifdef COVER_DEDUP_EN
  logic [WIDTH-1:0] seen_q, seen_d;

  assign mask   = seen_q;
  assign seen_d = seen_q | cap;

  always_ff @(posedge clock) begin
    if (reset) seen_q <= '0;
    else       seen_q <= seen_d;
  end
`else
  assign mask = '0;
`endif

  // Capture, round-robin select (upper half from rr_q first, else wrap), and next-state.
  always_comb begin
    load      = ~out_valid_q | out_ready;
    cap       = valid & {WIDTH{enable}} & ~mask;
    for (int i = 0; i < WIDTH; i++) ge_rr[i] = (i >= int'(rr_q));
    hi        = pending_q & ge_rr;
    search    = (|hi) ? hi : pending_q;
    sel_idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (search[i]) sel_idx = IDX_W'(i);
    end
    do_grant  = load & (|pending_q);
    grant_vec = do_grant ? (WIDTH'(1) << sel_idx) : '0;
    pending_d = (pending_q & ~grant_vec) | cap;
    merge_hit = |(cap & pending_q & ~grant_vec);

    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    rr_d        = rr_q;
    if (load) out_valid_d = do_grant;
    if (do_grant) begin
      out_index_d = COVER_INDEX + 64'(sel_idx);
      rr_d        = (sel_idx == IDX_W'(WIDTH - 1)) ? '0 : sel_idx + IDX_W'(1);
    end

    hit_d = hit_q;
    if (out_valid_q && out_ready && (hit_q != '1)) hit_d = hit_q + CNT_W'(1);
    merge_d = merge_q;
    if (merge_hit && (merge_q != '1)) merge_d = merge_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q   <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      hit_q       <= '0;
      merge_q     <= '0;
    end else begin
      pending_q   <= pending_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      hit_q       <= hit_d;
      merge_q     <= merge_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_index   = out_index_q;
  assign busy        = (|pending_q) | out_valid_q;
  assign hit_count   = hit_q;
  assign merge_count = merge_q;

`ifndef SYNTHESIS
  // Cover indices emitted by this instance must fall inside the design's cover space.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (COVER_INDEX + 64'(WIDTH) <= COVER_TOTAL)
        else $error("cover_toggle_sched: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end
  end
`endif

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Directed bench for cover_toggle_sched: latency, drain order, backpressure merging, enable, reset, fairness.
module tb_cover_toggle_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [21:0] valid;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_index;
  logic        busy;
  logic [15:0] hit_count;
  logic [15:0] merge_count;

  int checks   = 0;
  int failures = 0;
  int n;

`ifdef COVER_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  cover_toggle_sched #(.WIDTH(22), .COVER_INDEX(0), .COVER_TOTAL(38253)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .valid       (valid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .busy        (busy),
    .hit_count   (hit_count),
    .merge_count (merge_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; valid = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_index", out_index, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hits", 64'(hit_count), 64'd0);
    chk("rst_merge", 64'(merge_count), 64'd0);

    // Single hit: pending after one edge, report on the next.
    valid = 22'h000001; tick(); valid = '0;
    chk("lat_valid_c1", 64'(out_valid), 64'd0);
    chk("lat_busy_c1", 64'(busy), 64'd1);
    tick();
    chk("lat_valid_c2", 64'(out_valid), 64'd1);
    chk("lat_index_c2", out_index, 64'd0);
    tick();
    chk("lat_valid_c3", 64'(out_valid), 64'd0);
    chk("lat_busy_c3", 64'(busy), 64'd0);
    chk("lat_hits", 64'(hit_count), 64'd1);

    // Full vector drains in index order, one per cycle.
    do_reset();
    valid = 22'h3FFFFF; tick(); valid = '0;
    for (int k = 0; k < 22; k++) begin
      tick();
      chk($sformatf("drain_valid_%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("drain_index_%0d", k), out_index, 64'(k));
    end
    tick();
    chk("drain_done_valid", 64'(out_valid), 64'd0);
    chk("drain_done_busy", 64'(busy), 64'd0);
    chk("drain_hits", 64'(hit_count), 64'd22);

    // Backpressure: bit 0 stalled on output while bit 5 is hit ten times.
    do_reset();
    out_ready = 1'b0;
    valid = 22'h000001; tick(); valid = '0; tick();
    chk("bp_valid0", 64'(out_valid), 64'd1);
    chk("bp_index0", out_index, 64'd0);
    valid = 22'h000020;
    repeat (10) tick();
    valid = '0;
    chk("bp_merge", 64'(merge_count), DEDUP ? 64'd0 : 64'd9);
    tick(); tick();
    chk("bp_stable_valid", 64'(out_valid), 64'd1);
    chk("bp_stable_index", out_index, 64'd0);
    chk("bp_stall_hits", 64'(hit_count), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_valid", 64'(out_valid), 64'd1);
    chk("bp_rel_index", out_index, 64'd5);
    tick();
    chk("bp_idle_valid", 64'(out_valid), 64'd0);
    chk("bp_idle_busy", 64'(busy), 64'd0);
    chk("bp_hits", 64'(hit_count), 64'd2);
    chk("bp_merge_final", 64'(merge_count), DEDUP ? 64'd0 : 64'd9);

    // Same bit hit twice, twenty cycles apart.
    do_reset();
    n = 0;
    valid = 22'h000008; tick(); valid = '0;
    tick();
    chk("dup_index", out_index, 64'd3);
    if (out_valid) n++;
    repeat (18) begin tick(); if (out_valid) n++; end
    valid = 22'h000008; tick(); valid = '0;
    if (out_valid) n++;
    repeat (10) begin tick(); if (out_valid) n++; end
    chk("dup_reports", 64'(n), DEDUP ? 64'd1 : 64'd2);
    chk("dup_hits", 64'(hit_count), DEDUP ? 64'd1 : 64'd2);

    // Capture disabled: hits ignored.
    enable = 1'b0;
    valid = 22'h3FFFFF; tick(); valid = '0; tick();
    chk("en_valid", 64'(out_valid), 64'd0);
    chk("en_busy", 64'(busy), 64'd0);
    chk("en_hits", 64'(hit_count), DEDUP ? 64'd1 : 64'd2);
    enable = 1'b1;

    // Reset with ten bits pending discards everything.
    out_ready = 1'b0;
    valid = 22'h0003FF; tick(); valid = '0;
    chk("rp_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rp_valid", 64'(out_valid), 64'd0);
    chk("rp_index", out_index, 64'd0);
    chk("rp_busy", 64'(busy), 64'd0);
    chk("rp_hits", 64'(hit_count), 64'd0);
    chk("rp_merge", 64'(merge_count), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rp_quiet_%0d", k), 64'(out_valid), 64'd0);
    end

    // Fairness: after bit 21 the pointer wraps, so bit 0 goes first.
    do_reset();
    valid = 22'h200000; tick(); valid = '0; tick();
    chk("rr_first21", out_index, 64'd21);
    tick();
    chk("rr_first21_done", 64'(out_valid), 64'd0);
    valid = 22'h200001; tick(); valid = '0; tick();
    chk("rr_pair_a_valid", 64'(out_valid), 64'd1);
    chk("rr_pair_a_index", out_index, 64'd0);
    tick();
    chk("rr_pair_b_valid", 64'(out_valid), DEDUP ? 64'd0 : 64'd1);
`ifndef COVER_DEDUP_EN
    chk("rr_pair_b_index", out_index, 64'd21);
`endif
    tick();
    chk("rr_pair_done", 64'(out_valid), 64'd0);
    // Pointer at 6: bit 10 precedes bit 2.
    valid = 22'h000020; tick(); valid = '0; tick();
    chk("rr_b5", out_index, 64'd5);
    tick();
    valid = 22'h000404; tick(); valid = '0; tick();
    chk("rr_wrap_a", out_index, 64'd10);
    tick();
    chk("rr_wrap_b_valid", 64'(out_valid), 64'd1);
    chk("rr_wrap_b", out_index, 64'd2);
    tick();
    chk("rr_wrap_done", 64'(out_valid), 64'd0);
    chk("rr_hits", 64'(hit_count), DEDUP ? 64'd5 : 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
